uart_send_queue: RTL and testbench

UART_SEND_QUEUE -- requirements
Module: uart_send_queue

---
 rtl/uart_send_queue_pkg.sv | 14 +
 rtl/uart_send_queue_mem.sv | 26 ++
 rtl/uart_send_queue.sv | 89 ++++++++
 tb/tb_uart_send_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_send_queue_pkg.sv
// Shared constants for the UART send queue.
// Default depth, byte width and occupancy counter width.
package uart_send_queue_pkg;

  localparam int UQ_DEPTH  = 16;
  localparam int UQ_AW     = 4;
  localparam int UQ_BYTE_W = 8;

  // The occupancy counter needs one extra bit so it can hold DEPTH itself.
  function automatic int uq_cnt_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/uart_send_queue_mem.sv
// Byte storage for the send queue.
// One synchronous write port, one asynchronous read port.
module uart_send_queue_mem
  import uart_send_queue_pkg::*;
#(
  parameter int AW = UQ_AW,
  parameter int DW = UQ_BYTE_W
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Storage is never reset; entries are only read once written.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_send_queue.sv
// Send queue between BusControl and the Monitor.
// Edge-triggered push, first-word fall-through pop.
module uart_send_queue
  import uart_send_queue_pkg::*;
#(
  parameter int DEPTH = UQ_DEPTH,
  parameter int AW    = UQ_AW
) (
  input  logic                     MCLK_IN,
  input  logic                     RESET_n_IN,
  input  logic                     TRIGGER_IN,
  input  logic [UQ_BYTE_W-1:0]     BYTE_IN,
  output logic                     BUSY,
  output logic                     OUT_VALID,
  output logic [UQ_BYTE_W-1:0]     OUT_BYTE,
  input  logic                     OUT_READY_IN,
  output logic [uq_cnt_w(AW)-1:0]  COUNT,
  output logic                     OVERFLOW,
  input  logic                     OVERFLOW_CLR_IN
);

  localparam int CW = uq_cnt_w(AW);
  localparam logic [CW-1:0] L_FULL = CW'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_trig_prev;
  logic          r_ovf;

  logic w_push_req;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_drop;
  logic w_pop;

  assign w_push_req = TRIGGER_IN & ~r_trig_prev;
  assign w_full     = (r_count == L_FULL);
  assign w_empty    = (r_count == '0);
  assign w_push     = w_push_req & ~w_full;
  assign w_drop     = w_push_req & w_full;
  assign w_pop      = ~w_empty & OUT_READY_IN;

  assign BUSY      = w_full;
  assign OUT_VALID = ~w_empty;
  assign COUNT     = r_count;
  assign OVERFLOW  = r_ovf;

  // Previous trigger starts high so a held strobe at release is ignored.
  always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) r_trig_prev <= 1'b1;
    else             r_trig_prev <= TRIGGER_IN;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy separately.
  always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Sticky drop flag; a drop wins over a coincident clear.
  always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN)          r_ovf <= 1'b0;
    else if (w_drop)          r_ovf <= 1'b1;
    else if (OVERFLOW_CLR_IN) r_ovf <= 1'b0;
  end

  uart_send_queue_mem #(
    .AW (AW),
    .DW (UQ_BYTE_W)
  ) u_mem (
    .i_clk   (MCLK_IN),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (BYTE_IN),
    .i_raddr (r_rptr),
    .o_rdata (OUT_BYTE)
  );

endmodule

// File: tb/tb_uart_send_queue.sv
// Scoreboard bench for uart_send_queue.
// Directed stimulus; a negedge monitor checks every popped byte.
module tb_uart_send_queue;

  logic       clk;
  logic       rst_n;
  logic       trig;
  logic [7:0] byte_in;
  logic       busy;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       ready;
  logic [4:0] count;
  logic       ovf;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_send_queue dut (
    .MCLK_IN         (clk),
    .RESET_n_IN      (rst_n),
    .TRIGGER_IN      (trig),
    .BYTE_IN         (byte_in),
    .BUSY            (busy),
    .OUT_VALID       (out_valid),
    .OUT_BYTE        (out_byte),
    .OUT_READY_IN    (ready),
    .COUNT           (count),
    .OVERFLOW        (ovf),
    .OVERFLOW_CLR_IN (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    trig    = 1'b1;
    byte_in = b;
    if (acc) exp_q.push_back(b);
    step();
    trig = 1'b0;
    step();
  endtask

  task automatic drain(input string name);
    int n;
    ready = 1'b1;
    n = 0;
    while (count != 0 && n < 100) begin
      step();
      n++;
    end
    ready = 1'b0;
    chk({name, " drained count"}, count, 0);
    chk({name, " scoreboard empty"}, exp_q.size(), 0);
  endtask

  // Monitor: a pop happens at the next edge whenever valid and ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop: got 0x%0h expected no byte", out_byte);
      end else begin
        if (out_byte !== exp_q[0]) begin
          errors++;
          $display("FAIL pop: got 0x%0h expected 0x%0h",
                   out_byte, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    trig    = 1'b0;
    byte_in = 8'h00;
    ready   = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("reset count", count, 0);
    chk("reset valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset overflow", ovf, 0);

    // Single push with a held strobe.
    trig    = 1'b1;
    byte_in = 8'h41;
    exp_q.push_back(8'h41);
    #1;
    chk("single pre-edge valid", out_valid, 0);
    step();
    chk("single valid", out_valid, 1);
    chk("single count", count, 1);
    chk("single byte", out_byte, 8'h41);
    repeat (3) step();
    chk("single held count", count, 1);
    trig = 1'b0;
    step();
    drain("single");

    // Fill, overflow, ordered drain.
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    chk("fill busy", busy, 1);
    chk("fill count", count, 16);
    chk("fill no overflow", ovf, 0);
    push(8'hFF, 1'b0);
    chk("fill drop overflow", ovf, 1);
    chk("fill drop count", count, 16);
    drain("fill");
    chk("fill drained busy", busy, 0);

    // Overflow clear, then clear coincident with a drop.
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr overflow", ovf, 0);
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b1);
    ovf_clr = 1'b1;
    trig    = 1'b1;
    byte_in = 8'hFF;
    step();
    ovf_clr = 1'b0;
    trig    = 1'b0;
    step();
    chk("clr vs drop overflow", ovf, 1);
    chk("clr vs drop count", count, 16);

    // Full: push and pop in the same cycle -> push dropped.
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("full simul pre overflow", ovf, 0);
    trig    = 1'b1;
    byte_in = 8'hEE;
    ready   = 1'b1;
    step();
    ready = 1'b0;
    trig  = 1'b0;
    step();
    chk("full simul count", count, 15);
    chk("full simul overflow", ovf, 1);
    drain("full simul");

    // COUNT=5: push and pop in the same cycle.
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), 1'b1);
    chk("five count", count, 5);
    trig    = 1'b1;
    byte_in = 8'h55;
    ready   = 1'b1;
    exp_q.push_back(8'h55);
    step();
    ready = 1'b0;
    trig  = 1'b0;
    step();
    chk("five simul count", count, 5);
    drain("five");

    // Wrap-around.
    for (int i = 0; i < 10; i++) push(8'h60 + 8'(i), 1'b1);
    drain("wrap first");
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1'b1);
    chk("wrap busy", busy, 1);
    chk("wrap head", out_byte, 8'h80);
    drain("wrap second");

    // Reset mid-operation, trigger held across release.
    for (int i = 0; i < 7; i++) push(8'h70 + 8'(i), 1'b1);
    chk("mid count", count, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset count", count, 0);
    chk("mid reset valid", out_valid, 0);
    chk("mid reset busy", busy, 0);
    chk("mid reset overflow", ovf, 0);
    exp_q.delete();
    trig    = 1'b1;
    byte_in = 8'h99;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("release held count", count, 0);
    chk("release held valid", out_valid, 0);
    trig = 1'b0;
    step();
    push(8'h33, 1'b1);
    chk("post reset count", count, 1);
    chk("post reset byte", out_byte, 8'h33);
    drain("post reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
